ssd_scan_controller: RTL and testbench

- Time-multiplexed driver for the board's 8-digit common-anode seven-segment display; replaces ad-hoc scan logic in top-level modules.
- Holds a shadow copy of the digit data, updated atomically at frame boundaries through a req/ack handshake.
- Per-digit enable and leading-zero blanking.
- Inserts an all-off blanking gap before every digit to suppress ghosting.

---
 rtl/ssd_scan_controller.sv | 143 ++++++++++++++
 tb/tb_ssd_scan_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_controller.sv
// Time-multiplexed common-anode seven-segment scanner with a frame-synchronous
// shadow register loaded through a req/ack handshake, per-digit enable and LZ blanking.
module ssd_scan_controller #(
  parameter int DIGITS = 8,
  parameter int DWELL  = 250000,
  parameter int BLANK  = 2000
) (
  input  logic                  ClkPort,
  input  logic                  Reset_n,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     en_mask,
  input  logic                  lz_blank,
  input  logic                  load_req,
  output logic                  load_ack,
  output logic [DIGITS-1:0]     anodes,
  output logic [7:0]            cathodes,
  output logic                  frame_start
);

  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_RST, S_BLANK, S_DRIVE} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_val;
  logic [DIGITS-1:0]     r_dp;
  logic [DIGITS-1:0]     r_mask;
  logic                  r_lz;
  logic                  r_load_ack;
  logic                  r_frame_start;
  logic [DIGITS-1:0]     r_anodes;
  logic [7:0]            r_cathodes;

  logic                  w_upper_zero;
  logic                  w_lit;
  logic [3:0]            w_nib;
  logic                  w_boundary;

  function automatic logic [6:0] f_seg(input logic [3:0] n);
    case (n)
      4'h0: f_seg = 7'b0000001;
      4'h1: f_seg = 7'b1001111;
      4'h2: f_seg = 7'b0010010;
      4'h3: f_seg = 7'b0000110;
      4'h4: f_seg = 7'b1001100;
      4'h5: f_seg = 7'b0100100;
      4'h6: f_seg = 7'b0100000;
      4'h7: f_seg = 7'b0001111;
      4'h8: f_seg = 7'b0000000;
      4'h9: f_seg = 7'b0000100;
      4'hA: f_seg = 7'b0001000;
      4'hB: f_seg = 7'b1100000;
      4'hC: f_seg = 7'b0110001;
      4'hD: f_seg = 7'b1000010;
      4'hE: f_seg = 7'b0110000;
      default: f_seg = 7'b0111000;
    endcase
  endfunction

  // Digit idx is LZ-blanked when it and every more-significant nibble are zero.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (k >= 32'(r_idx) && r_val[4*k +: 4] != 4'h0) w_upper_zero = 1'b0;
    end
    w_nib      = r_val[{r_idx, 2'b00} +: 4];
    w_lit      = r_mask[r_idx] && !(r_lz && (r_idx != '0) && w_upper_zero);
    w_boundary = (r_state == S_RST) ||
                 ((r_state == S_DRIVE) && (r_cnt == CW'(DWELL - 1)) &&
                  (r_idx == IW'(DIGITS - 1)));
  end

  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= S_RST;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_val         <= '0;
      r_dp          <= '0;
      r_mask        <= '0;
      r_lz          <= 1'b0;
      r_load_ack    <= 1'b0;
      r_frame_start <= 1'b0;
      r_anodes      <= '1;
      r_cathodes    <= '1;
    end else begin
      r_load_ack    <= 1'b0;
      r_frame_start <= 1'b0;
      unique case (r_state)
        S_RST: begin
          r_state <= S_BLANK;
          r_idx   <= '0;
          r_cnt   <= '0;
        end
        S_BLANK: begin
          if (r_cnt == CW'(BLANK - 1)) begin
            r_state <= S_DRIVE;
            r_cnt   <= '0;
            if (w_lit) begin
              r_anodes   <= ~(DIGITS'(1) << r_idx);
              r_cathodes <= {f_seg(w_nib), ~r_dp[r_idx]};
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRIVE: begin
          if (r_cnt == CW'(DWELL - 1)) begin
            r_state    <= S_BLANK;
            r_cnt      <= '0;
            r_anodes   <= '1;
            r_cathodes <= '1;
            r_idx      <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_RST;
      endcase
      if (w_boundary) begin
        r_frame_start <= 1'b1;
        if (load_req) begin
          r_val      <= value_in;
          r_dp       <= dp_in;
          r_mask     <= en_mask;
          r_lz       <= lz_blank;
          r_load_ack <= 1'b1;
        end
      end
    end
  end

  assign load_ack    = r_load_ack;
  assign frame_start = r_frame_start;
  assign anodes      = r_anodes;
  assign cathodes    = r_cathodes;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller: DIGITS=4, DWELL=4, BLANK=2 (24-cycle frame).
module tb_ssd_scan_controller;

  localparam int D  = 4;
  localparam int DW = 4;
  localparam int BL = 2;
  localparam int FR = 24;

  logic        ClkPort  = 1'b0;
  logic        Reset_n  = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in    = '0;
  logic [3:0]  en_mask  = '0;
  logic        lz_blank = 1'b0;
  logic        load_req = 1'b0;
  logic        load_ack;
  logic [3:0]  anodes;
  logic [7:0]  cathodes;
  logic        frame_start;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] o_an [4][FR];
  logic [7:0] o_ct [4][FR];
  logic       o_fs [4][FR];
  logic       o_ak [4][FR];

  ssd_scan_controller #(.DIGITS(D), .DWELL(DW), .BLANK(BL)) dut (
    .ClkPort     (ClkPort),
    .Reset_n     (Reset_n),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .en_mask     (en_mask),
    .lz_blank    (lz_blank),
    .load_req    (load_req),
    .load_ack    (load_ack),
    .anodes      (anodes),
    .cathodes    (cathodes),
    .frame_start (frame_start)
  );

  always #5 ClkPort = ~ClkPort;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge ClkPort);
    @(negedge ClkPort);
  endtask

  task automatic set_in(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] m,
                        input logic lz);
    value_in = v;
    dp_in    = dp;
    en_mask  = m;
    lz_blank = lz;
  endtask

  // Entered at position 0 of a frame; leaves at position 0 of the next one.
  task automatic run_frame(input int f, input int on_pos, input int off_pos);
    for (int p = 0; p < FR; p++) begin
      o_an[f][p] = anodes;
      o_ct[f][p] = cathodes;
      o_fs[f][p] = frame_start;
      o_ak[f][p] = load_ack;
      if (p == on_pos)  load_req = 1'b1;
      if (p == off_pos) load_req = 1'b0;
      tick();
    end
  endtask

  function automatic logic [3:0] f_an(input int p, input logic [15:0] ea);
    if (p % 6 < 2) return 4'hF;
    return ea[(p / 6) * 4 +: 4];
  endfunction

  function automatic logic [7:0] f_ct(input int p, input logic [31:0] ec);
    if (p % 6 < 2) return 8'hFF;
    return ec[(p / 6) * 8 +: 8];
  endfunction

  task automatic test_reset;
    Reset_n  = 1'b0;
    load_req = 1'b0;
    repeat (3) @(negedge ClkPort);
    n_cmp++; if (anodes !== 4'hF) begin n_fail++; $display("FAIL reset_anodes got %b want 1111", anodes); end
    n_cmp++; if (cathodes !== 8'hFF) begin n_fail++; $display("FAIL reset_cathodes got %h want ff", cathodes); end
    n_cmp++; if (load_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", load_ack); end
    n_cmp++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b want 0", frame_start); end
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_idle;
    logic [15:0] ea [4];
    logic [31:0] ec [4];
    logic        xa [4];
    int          nf;
    nf = 2;
    for (int f = 0; f < nf; f++) begin ea[f] = 16'hFFFF; ec[f] = 32'hFFFFFFFF; xa[f] = 1'b0; end
    run_frame(0, -1, -1);
    run_frame(1, -1, -1);
    for (int f = 0; f < nf; f++) for (int p = 0; p < FR; p++) begin
      logic [13:0] got, exp;
      got = {o_an[f][p], o_ct[f][p], o_fs[f][p], o_ak[f][p]};
      exp = {f_an(p, ea[f]), f_ct(p, ec[f]), 1'(p == 0), 1'(p == 0 && xa[f])};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL idle f=%0d p=%0d got an/cat/fs/ack=%b/%b/%b/%b want %b/%b/%b/%b", f, p,
                 got[13:10], got[9:2], got[1], got[0], exp[13:10], exp[9:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_load;
    logic [15:0] ea [4];
    logic [31:0] ec [4];
    logic        xa [4];
    int          nf;
    nf = 3;
    ea[0] = 16'hFFFF; ec[0] = 32'hFFFFFFFF; xa[0] = 1'b0;
    ea[1] = 16'h7BDE; ec[1] = 32'h9F251198; xa[1] = 1'b1;
    ea[2] = 16'h7BDE; ec[2] = 32'h9F251198; xa[2] = 1'b0;
    set_in(16'h12A4, 4'b0001, 4'b1111, 1'b0);
    load_req = 1'b1;
    run_frame(0, -1, -1);
    load_req = 1'b0;
    set_in(16'hFFFF, 4'b1111, 4'b0000, 1'b1);
    run_frame(1, -1, -1);
    run_frame(2, -1, -1);
    for (int f = 0; f < nf; f++) for (int p = 0; p < FR; p++) begin
      logic [13:0] got, exp;
      got = {o_an[f][p], o_ct[f][p], o_fs[f][p], o_ak[f][p]};
      exp = {f_an(p, ea[f]), f_ct(p, ec[f]), 1'(p == 0), 1'(p == 0 && xa[f])};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL load f=%0d p=%0d got an/cat/fs/ack=%b/%b/%b/%b want %b/%b/%b/%b", f, p,
                 got[13:10], got[9:2], got[1], got[0], exp[13:10], exp[9:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_midframe;
    logic [15:0] ea [4];
    logic [31:0] ec [4];
    logic        xa [4];
    int          nf;
    nf = 4;
    ea[0] = 16'h7BDE; ec[0] = 32'h9F251198; xa[0] = 1'b0;
    ea[1] = 16'h7BDE; ec[1] = 32'h48411F01; xa[1] = 1'b1;
    ea[2] = 16'h7BDE; ec[2] = 32'h48411F01; xa[2] = 1'b0;
    ea[3] = 16'h7BDE; ec[3] = 32'h48411F01; xa[3] = 1'b0;
    set_in(16'h5678, 4'b1000, 4'b1111, 1'b0);
    run_frame(0, 5, -1);
    load_req = 1'b0;
    run_frame(1, -1, -1);
    set_in(16'h0000, 4'b0000, 4'b0000, 1'b0);
    run_frame(2, 3, 10);
    run_frame(3, -1, -1);
    for (int f = 0; f < nf; f++) for (int p = 0; p < FR; p++) begin
      logic [13:0] got, exp;
      got = {o_an[f][p], o_ct[f][p], o_fs[f][p], o_ak[f][p]};
      exp = {f_an(p, ea[f]), f_ct(p, ec[f]), 1'(p == 0), 1'(p == 0 && xa[f])};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL midframe f=%0d p=%0d got an/cat/fs/ack=%b/%b/%b/%b want %b/%b/%b/%b", f, p,
                 got[13:10], got[9:2], got[1], got[0], exp[13:10], exp[9:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_lz;
    logic [15:0] ea [4];
    logic [31:0] ec [4];
    logic        xa [4];
    int          nf;
    nf = 2;
    ea[0] = 16'h7BDE; ec[0] = 32'h48411F01; xa[0] = 1'b0;
    ea[1] = 16'hFFFE; ec[1] = 32'hFFFFFF49; xa[1] = 1'b1;
    set_in(16'h0005, 4'b0000, 4'b1111, 1'b1);
    load_req = 1'b1;
    run_frame(0, -1, -1);
    load_req = 1'b0;
    run_frame(1, -1, -1);
    for (int f = 0; f < nf; f++) for (int p = 0; p < FR; p++) begin
      logic [13:0] got, exp;
      got = {o_an[f][p], o_ct[f][p], o_fs[f][p], o_ak[f][p]};
      exp = {f_an(p, ea[f]), f_ct(p, ec[f]), 1'(p == 0), 1'(p == 0 && xa[f])};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL lz f=%0d p=%0d got an/cat/fs/ack=%b/%b/%b/%b want %b/%b/%b/%b", f, p,
                 got[13:10], got[9:2], got[1], got[0], exp[13:10], exp[9:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ea [4];
    logic [31:0] ec [4];
    logic        xa [4];
    int          nf;
    nf = 3;
    ea[0] = 16'hFFFE; ec[0] = 32'hFFFFFF49; xa[0] = 1'b0;
    ea[1] = 16'hFFFE; ec[1] = 32'hFFFFFF03; xa[1] = 1'b1;
    ea[2] = 16'hFBDE; ec[2] = 32'hFF490303; xa[2] = 1'b1;
    set_in(16'h0000, 4'b0000, 4'b1111, 1'b1);
    load_req = 1'b1;
    run_frame(0, -1, -1);
    set_in(16'h0500, 4'b0000, 4'b1111, 1'b1);
    run_frame(1, -1, -1);
    load_req = 1'b0;
    run_frame(2, -1, -1);
    for (int f = 0; f < nf; f++) for (int p = 0; p < FR; p++) begin
      logic [13:0] got, exp;
      got = {o_an[f][p], o_ct[f][p], o_fs[f][p], o_ak[f][p]};
      exp = {f_an(p, ea[f]), f_ct(p, ec[f]), 1'(p == 0), 1'(p == 0 && xa[f])};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL back_to_back f=%0d p=%0d got an/cat/fs/ack=%b/%b/%b/%b want %b/%b/%b/%b", f, p,
                 got[13:10], got[9:2], got[1], got[0], exp[13:10], exp[9:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_mask;
    logic [15:0] ea [4];
    logic [31:0] ec [4];
    logic        xa [4];
    int          nf;
    nf = 3;
    ea[0] = 16'hFBDE; ec[0] = 32'hFF490303; xa[0] = 1'b0;
    ea[1] = 16'hFBFE; ec[1] = 32'hFF25FF98; xa[1] = 1'b1;
    ea[2] = 16'hFBFE; ec[2] = 32'hFF25FF98; xa[2] = 1'b0;
    set_in(16'h12A4, 4'b0001, 4'b0101, 1'b0);
    load_req = 1'b1;
    run_frame(0, -1, -1);
    load_req = 1'b0;
    run_frame(1, -1, -1);
    run_frame(2, -1, -1);
    for (int f = 0; f < nf; f++) for (int p = 0; p < FR; p++) begin
      logic [13:0] got, exp;
      got = {o_an[f][p], o_ct[f][p], o_fs[f][p], o_ak[f][p]};
      exp = {f_an(p, ea[f]), f_ct(p, ec[f]), 1'(p == 0), 1'(p == 0 && xa[f])};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL mask f=%0d p=%0d got an/cat/fs/ack=%b/%b/%b/%b want %b/%b/%b/%b", f, p,
                 got[13:10], got[9:2], got[1], got[0], exp[13:10], exp[9:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [15:0] ea [4];
    logic [31:0] ec [4];
    logic        xa [4];
    int          nf;
    repeat (3) tick();
    n_cmp++; if (anodes !== 4'b1110) begin n_fail++; $display("FAIL pre_reset_anodes got %b want 1110", anodes); end
    n_cmp++; if (cathodes !== 8'h98) begin n_fail++; $display("FAIL pre_reset_cathodes got %h want 98", cathodes); end
    Reset_n = 1'b0;
    #2;
    n_cmp++; if (anodes !== 4'hF) begin n_fail++; $display("FAIL async_reset_anodes got %b want 1111", anodes); end
    n_cmp++; if (cathodes !== 8'hFF) begin n_fail++; $display("FAIL async_reset_cathodes got %h want ff", cathodes); end
    repeat (2) @(negedge ClkPort);
    n_cmp++; if ({anodes, cathodes, frame_start, load_ack} !== {4'hF, 8'hFF, 2'b00})
      begin n_fail++; $display("FAIL held_reset got %b/%h/%b/%b want 1111/ff/0/0", anodes, cathodes, frame_start, load_ack); end
    Reset_n = 1'b1;
    tick();
    nf = 2;
    for (int f = 0; f < nf; f++) begin ea[f] = 16'hFFFF; ec[f] = 32'hFFFFFFFF; xa[f] = 1'b0; end
    run_frame(0, -1, -1);
    run_frame(1, -1, -1);
    for (int f = 0; f < nf; f++) for (int p = 0; p < FR; p++) begin
      logic [13:0] got, exp;
      got = {o_an[f][p], o_ct[f][p], o_fs[f][p], o_ak[f][p]};
      exp = {f_an(p, ea[f]), f_ct(p, ec[f]), 1'(p == 0), 1'(p == 0 && xa[f])};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL post_reset f=%0d p=%0d got an/cat/fs/ack=%b/%b/%b/%b want %b/%b/%b/%b", f, p,
                 got[13:10], got[9:2], got[1], got[0], exp[13:10], exp[9:2], exp[1], exp[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load();
    test_midframe();
    test_lz();
    test_back_to_back();
    test_mask();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
